// File: rtl/dm_pkg.sv
// Shared encodings and default address window for the DM access controller.
package dm_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  // ST_ERR is the one-cycle slot that gives rejected requests the same
  // two-cycle latency as accepted ones.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ERR,
    ST_RESP
  } state_e;

  localparam logic [31:0] DM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] DM_SIZE_DEF = 32'h0000_3000;

  // Unsigned wrap makes addresses below base land far above size.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response and DM-port signal bundle for dm_access_ctrl.
interface dm_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_wpc;
  logic [31:0] dm_rd;

  // Pipeline / environment side: issues requests and models DM read data.
  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    output dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_addr, dm_wd, dm_be, dm_wpc
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    input  dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_wd, dm_be, dm_wpc
  );

endinterface

// File: rtl/dm_lane_ext.sv
// Combinational load extractor: picks byte/half/word from a DM word and extends it.
module dm_lane_ext
  import dm_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];

  // NOTE: every output of an always_comb gets a default first, otherwise an
  // unlisted case leaves it holding its old value and a latch is inferred.
  always_comb begin
    data_o = rd_i;
    unique case (size_i)
      SIZE_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// CPU-side DM access controller: one load/store per handshake, lane masking,
// load extension. Optional macro ALIGN_CHECK_EN rejects misaligned half/word.
module dm_access_ctrl #(
  parameter logic [31:0] DM_BASE = dm_pkg::DM_BASE_DEF,
  parameter logic [31:0] DM_SIZE = dm_pkg::DM_SIZE_DEF
) (
  input logic            clk_i,
  input logic            rst_i,
  dm_access_ctrl_if.slave bus
);

  import dm_pkg::*;

  state_e      state_q, state_d;
  size_e       req_size;
  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [1:0]  off_eff;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [31:0] ext_data;

  logic [3:0]  be_q;
  logic [1:0]  off_q;
  size_e       size_q;
  logic        sign_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] wpc_q;
  logic [31:0] rdata_q;

  assign req_size = size_e'(bus.req_size);
  assign accept   = (state_q == ST_IDLE) && bus.req_valid;

`ifdef ALIGN_CHECK_EN
  assign misalign = ((req_size == SIZE_HALF) && bus.req_addr[0]) ||
                    ((req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = !addr_in_range(bus.req_addr, DM_BASE, DM_SIZE) ||
                   (req_size == SIZE_RSVD) || misalign;

  // Lane mask and replicated store data; misaligned low bits are dropped.
  always_comb begin
    off_eff = bus.req_addr[1:0];
    be_d    = 4'b0000;
    wd_d    = bus.req_wdata;
    unique case (req_size)
      SIZE_BYTE: begin
        be_d = 4'b0001 << bus.req_addr[1:0];
        wd_d = {4{bus.req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        off_eff = {bus.req_addr[1], 1'b0};
        be_d    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wd_d    = {2{bus.req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        off_eff = 2'b00;
        be_d    = 4'b1111;
      end
      default: be_d = 4'b0000;
    endcase
    if (req_err || !bus.req_we) be_d = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)         state_d = ST_ERR;
          else if (bus.req_we) state_d = ST_WRITE;
          else                 state_d = ST_READ;
        end
      end
      ST_WRITE, ST_READ, ST_ERR: state_d = ST_RESP;
      default:                   state_d = ST_IDLE;
    endcase
  end

  dm_lane_ext u_lane_ext (
    .rd_i   (bus.dm_rd),
    .off_i  (off_q),
    .size_i (size_q),
    .sign_i (sign_q),
    .data_o (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      be_q    <= 4'b0000;
      off_q   <= 2'b00;
      size_q  <= SIZE_BYTE;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      wpc_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        be_q    <= be_d;
        off_q   <= off_eff;
        size_q  <= req_size;
        sign_q  <= bus.req_sign;
        err_q   <= req_err;
        addr_q  <= {bus.req_addr[31:2], 2'b00};
        wd_q    <= wd_d;
        wpc_q   <= bus.req_pc;
        rdata_q <= 32'h0;
      end else if (state_q == ST_READ) begin
        rdata_q <= ext_data;
      end
    end
  end

  // dm_be is gated by the state register so reset kills a write instantly.
  assign bus.dm_be      = (state_q == ST_WRITE) ? be_q : 4'b0000;
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.dm_addr    = addr_q;
  assign bus.dm_wd      = wd_q;
  assign bus.dm_wpc     = wpc_q;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- CPU-side initiator for the DM port (Addr/WD/ByteEnable/WPC in, RD out).
- Accepts one load/store request per handshake and drives the DM write lanes for exactly one cycle on stores.
- On loads, registers the word read from DM, then extracts and sign/zero-extends the requested byte, half or word.
- Sits between the pipeline MEM stage and DM; the M stage stalls while req_ready=0.

Parameters:
- DM_BASE, 32'h0000_0000, lowest valid DM byte address.
- DM_SIZE, 32'h0000_3000, DM size in bytes; valid range is [DM_BASE, DM_BASE+DM_SIZE).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the instruction, forwarded to DM.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  request rejected; no DM write performed.
- dm_addr  out  32  {addr[31:2],2'b00}.
- dm_wd  out  32  lane-replicated store data.
- dm_be  out  4  byte write enables; nonzero only in WRITE.
- dm_wpc  out  32  captured req_pc.
- dm_rd  in  32  DM combinational read data for dm_addr.

Behaviour:
- One clock (Clock); reset (Reset) is asynchronous and active-high.
- All outputs are registered or decoded from the state register. Reset forces the following immediately, without waiting for a clock edge:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0;
  - dm_be = 0, resp_rdata = 0, dm_addr/dm_wd/dm_wpc = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the request.
  - Next state: ERR-RESP if invalid; WRITE if req_we = 1; otherwise READ.
- WRITE:
  - Active for exactly one cycle; dm_be = lane mask.
  - DM commits at the closing edge; next state RESP.
- READ:
  - Active for one cycle; dm_be = 0.
  - At the closing edge, register the extracted dm_rd into resp_rdata; next state RESP.
- RESP:
  - resp_valid = 1 for one cycle; next state IDLE.
  - resp_err is held 1 in this cycle for rejected requests.
- Latency: request accept → resp_valid takes 2 cycles (valid or rejected). Throughput is 1 request per 3 cycles.
- Lane mask and store data, with k = addr[1:0]:
  - byte: dm_be = 1<<k, dm_wd = {4{wdata[7:0]}}.
  - half: dm_be = addr[1] ? 4'b1100 : 4'b0011, dm_wd = {2{wdata[15:0]}}.
  - word: dm_be = 4'b1111, dm_wd = wdata.
- Load extraction:
  - byte = dm_rd[8k+7:8k].
  - half = dm_rd[16*addr[1]+15 : 16*addr[1]].
  - Result is extended per req_sign; word loads pass dm_rd unchanged.
- Invalid request (always checked): address outside [DM_BASE, DM_BASE+DM_SIZE), or req_size = 3.
  - dm_be stays 0; resp_err = 1; resp_rdata = 0.
- Requests arriving while req_ready = 0 are ignored; the requester must hold req_valid.
- Reset during WRITE: dm_be drops to 0 asynchronously, so the write is either complete or never happened. No partial-lane write is permitted.

Optional Feature:
- ALIGN_CHECK_EN defined:
  - Half access with addr[0] = 1, or word access with addr[1:0] ≠ 0, is rejected through ERR-RESP.
  - No DM write occurs.
- Not defined:
  - Misaligned low bits are forced to 0: half ignores addr[0], word ignores addr[1:0].
  - The access then proceeds normally with resp_err = 0.

Decomposition:
- Shared package dm_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encodings ST_IDLE/ST_WRITE/ST_READ/ST_RESP;
  - default DM_BASE/DM_SIZE constants.
- One sub-module, dm_lane_ext: combinational load extractor (dm_rd, addr[1:0], size, sign → 32-bit result).
  - The top holds the FSM, request capture, and mask/replication logic.

Test Plan:
- Store half 0x11223344 @0x2002 → WRITE cycle with dm_addr = 0x2000, dm_be = 4'b1100, dm_wd = 0x33443344; resp_valid 2 cycles after accept, resp_err = 0.
- Load byte signed @0x2003 with dm_rd = 0x81223344 → resp_rdata = 0xFFFFFF81. Same load unsigned → 0x00000081.
- Load half signed @0x2000 with dm_rd = 0xAABBCCDD → 0xFFFFCCDD. Load word @0x2004 → 0xAABBCCDD with dm_be = 0 throughout.
- Store word @0x3000 (out of range), and req_size = 3 @0x0000 → dm_be never nonzero; resp_err = 1, resp_rdata = 0.
- Store word @0x1002:
  - with ALIGN_CHECK_EN → resp_err = 1, no write;
  - without it → dm_addr = 0x1000, dm_be = 4'b1111.
- Assert Reset asynchronously mid-WRITE (dm_be = 4'b1111) → dm_be = 0 and req_ready = 1 before the next edge. A new request is accepted right after Reset deasserts.
